// File: rtl/credit_sender.sv
// credit_sender
//   Transmit end of a credit-managed FIFO link. It takes beats from an
//   upstream ready/valid port and forwards each one through a single output
//   register to a remote receiver FIFO. The counter tracks free receiver slots,
//   so a beat is only sent when the receiver is known to have room for it.
//
// Parameters
//   DATA_WIDTH  payload width in bits
//   CREDITS     receiver FIFO depth, which is also the initial credit count (1..255)
//   CNT_WIDTH   credit counter width; 2**CNT_WIDTH must exceed CREDITS
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-low reset
//   valid_i       upstream beat valid
//   data_i        upstream payload
//   ready_o       a beat can be accepted this cycle (at least one credit left)
//   valid_o       one-cycle pulse, beat presented to the receiver
//   data_o        payload, meaningful only while valid_o is high
//   credit_i      receiver freed one slot
//   credit_cnt_o  credits currently available
//   idle_o        all credits home and nothing on the output register
//   err_o         sticky: a credit came back while the counter was already full
module credit_sender #(
    parameter int DATA_WIDTH = 32,
    parameter int CREDITS    = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic [CNT_WIDTH-1:0]  credit_cnt_o,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  cnt;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  err;
    logic                  acc;

    // Next credit count. A simultaneous send and return cancel out, which is
    // legal even when full because the send frees a slot first. A lone return
    // while full is illegal and saturates instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] next_cnt(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 take,
        input logic                 give
    );
        logic [CNT_WIDTH-1:0] res;
        res = cur;
        case ({take, give})
            2'b10:   res = cur - ONE_CNT;
            2'b01:   res = (cur == FULL_CNT) ? cur : cur + ONE_CNT;
            default: res = cur;
        endcase
        return res;
    endfunction

    function automatic logic credit_overflow(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 take,
        input logic                 give
    );
        return give && !take && (cur == FULL_CNT);
    endfunction

    // Stage p0: accept decision, driven only by registered state on the ready side
    assign ready_o = (cnt != '0);
    assign acc     = valid_i & ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= FULL_CNT;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            err     <= 1'b0;
        end else begin
            vld_p1 <= acc;
            if (acc) begin
                data_p1 <= data_i;
            end
            cnt <= next_cnt(cnt, acc, credit_i);
            if (credit_overflow(cnt, acc, credit_i)) begin
                err <= 1'b1;
            end
        end
    end

    // Stage p1: registered beat toward the receiver
    assign valid_o      = vld_p1;
    assign data_o       = data_p1;
    assign credit_cnt_o = cnt;
    assign err_o        = err;
    assign idle_o       = (cnt == FULL_CNT) && !vld_p1;

endmodule

// File: tb/tb_credit_sender.sv
module tb_credit_sender;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          credit_i;
    logic [CW-1:0] credit_cnt_o;
    logic          idle_o;
    logic          err_o;

    credit_sender #(.DATA_WIDTH(DW), .CREDITS(NC), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .credit_cnt_o (credit_cnt_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full set of observable outputs for a given expected state.
    task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                             input int ecnt, input logic eerr);
        check({tag, ".valid_o"}, 32'(valid_o), 32'(ev));
        if (ev) check({tag, ".data_o"}, data_o, ed);
        check({tag, ".cnt"}, 32'(credit_cnt_o), 32'(ecnt));
        check({tag, ".ready_o"}, 32'(ready_o), 32'(ecnt != 0));
        check({tag, ".idle_o"}, 32'(idle_o), 32'((ecnt == NC) && !ev));
        check({tag, ".err_o"}, 32'(err_o), 32'(eerr));
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        c;
        logic        ev;
        logic [31:0] ed;
        int          ecnt;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [31:0] d, logic c,
                                logic ev, logic [31:0] ed, int ecnt, logic eerr);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.ev = ev; r.ed = ed; r.ecnt = ecnt; r.eerr = eerr;
        return r;
    endfunction

    task automatic cycle(input logic v, input logic [31:0] d, input logic c);
        valid_i  = v;
        data_i   = d;
        credit_i = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase
    int          m_cnt;
    logic        m_err;
    logic        m_v;
    logic [31:0] m_d;
    int          outstanding;

    initial begin
        rst      = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        credit_i = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", 1'b0, 32'h0, NC, 1'b0);
        check("reset_hold.data_o", data_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("reset_rel", 1'b0, 32'h0, NC, 1'b0);

        // Burst to empty, resume, simultaneous send/return, overflow
        tbl.push_back(mk(1, 32'hA0, 0, 1, 32'hA0, 3, 0));
        tbl.push_back(mk(1, 32'hA1, 0, 1, 32'hA1, 2, 0));
        tbl.push_back(mk(1, 32'hA2, 0, 1, 32'hA2, 1, 0));
        tbl.push_back(mk(1, 32'hA3, 0, 1, 32'hA3, 0, 0));
        tbl.push_back(mk(1, 32'hA4, 0, 0, 32'hA3, 0, 0));
        tbl.push_back(mk(1, 32'hA4, 1, 0, 32'hA3, 1, 0));
        tbl.push_back(mk(1, 32'hA4, 0, 1, 32'hA4, 0, 0));
        tbl.push_back(mk(0, 32'h00, 1, 0, 32'hA4, 1, 0));
        tbl.push_back(mk(0, 32'h00, 1, 0, 32'hA4, 2, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 32'hB0 + i, 1, 1, 32'hB0 + i, 2, 0));
        tbl.push_back(mk(0, 32'h00, 1, 0, 32'hB9, 3, 0));
        tbl.push_back(mk(0, 32'h00, 1, 0, 32'hB9, 4, 0));
        tbl.push_back(mk(1, 32'hD0, 1, 1, 32'hD0, 4, 0));
        tbl.push_back(mk(0, 32'h00, 1, 0, 32'hD0, 4, 1));
        tbl.push_back(mk(1, 32'hC0, 0, 1, 32'hC0, 3, 1));
        tbl.push_back(mk(0, 32'h00, 1, 0, 32'hC0, 4, 1));
        tbl.push_back(mk(1, 32'hE0, 0, 1, 32'hE0, 3, 1));
        tbl.push_back(mk(1, 32'hE1, 0, 1, 32'hE1, 2, 1));
        tbl.push_back(mk(1, 32'hE2, 0, 1, 32'hE2, 1, 1));

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].c);
            check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ecnt, tbl[i].eerr);
        end

        // Async reset between edges while a beat is on the output
        valid_i  = 1'b0;
        credit_i = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("async_rst.valid_o", 32'(valid_o), 32'h0);
        check("async_rst.cnt", 32'(credit_cnt_o), 32'(NC));
        check("async_rst.err_o", 32'(err_o), 32'h0);
        check("async_rst.data_o", data_o, 32'h0);
        check("async_rst.idle_o", 32'(idle_o), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", 1'b0, 32'h0, NC, 1'b0);

        // Random traffic against a receiver-occupancy model
        m_cnt = NC; m_err = 0; m_v = 0; m_d = 0; outstanding = 0;
        for (int k = 0; k < 3000; k++) begin
            logic       v, c, acc;
            logic [31:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            if (outstanding > 0) c = ($urandom_range(0, 2) == 0);
            else                 c = ($urandom_range(0, 63) == 0);
            acc = v && (m_cnt > 0);
            if (acc) begin
                m_d = d;
                outstanding++;
            end
            m_v = acc;
            if (c && outstanding > 0) outstanding--;
            if (acc && !c) m_cnt--;
            else if (!acc && c) begin
                if (m_cnt == NC) m_err = 1;
                else m_cnt++;
            end
            cycle(v, d, c);
            check_all("rand", m_v, m_d, m_cnt, m_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/credit_sender.md
# credit_sender

Upstream-facing ready/valid to downstream credit-based link converter for inter-stage queues in the core pipeline. Accepts beats on a ready/valid port and forwards them, registered, to a remote receiving FIFO whose free slots are tracked as credits; it is the transmit end of a credit-managed FIFO link. The block never sends a beat the receiver cannot store, so the receiver needs no ready back-pressure wire.

## Interface
- DATA_WIDTH, 32, payload width in bits
- CREDITS, 4, receiver FIFO depth = initial credit count; legal range 1..255
- CNT_WIDTH, 3, credit counter width; must satisfy 2^CNT_WIDTH > CREDITS
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk at system level)
- valid_i  input  1  upstream beat valid
- data_i  input  DATA_WIDTH  upstream payload
- ready_o  output  1  block can accept a beat this cycle
- valid_o  output  1  one-cycle pulse: beat presented to receiver, receiver must capture
- data_o  output  DATA_WIDTH  payload, meaningful only when valid_o=1
- credit_i  input  1  receiver freed one slot (at most one credit per cycle)
- credit_cnt_o  output  CNT_WIDTH  current available credits
- idle_o  output  1  credit_cnt_o == CREDITS and valid_o == 0 (all slots free, link drained)
- err_o  output  1  sticky: credit returned while counter already at CREDITS

## Operation
- Accept: acc = valid_i & ready_o. ready_o = (credit_cnt != 0); purely from register state, no combinational path from valid_i or credit_i.
- On acc: data_o <= data_i, valid_o <= 1 next cycle. Without acc: valid_o <= 0, data_o holds last value.
- Credit counter update per cycle, by case:
  - acc=1, credit_i=0: cnt <= cnt - 1
  - acc=0, credit_i=1: cnt <= cnt + 1, unless cnt == CREDITS -> cnt unchanged, err_o <= 1
  - acc=1, credit_i=1: cnt unchanged (net zero; legal even at cnt == CREDITS since the decrement makes room)
  - neither: unchanged
- Counter never underflows (ready_o gates acc) and never exceeds CREDITS (saturate on illegal return).
- err_o cleared only by reset.
- Data ordering: beats leave in acceptance order; no internal storage beyond the single output register.
- No state machine beyond counter; block is fully pipelined, one beat per cycle while credits > 0.

## Timing
- Reset values (while rst=0): credit_cnt_o = CREDITS, valid_o = 0, data_o = 0, err_o = 0, ready_o = 1, idle_o = 1.
- Reset mid-transfer: in-flight valid_o dropped immediately (async), counter restored to CREDITS; receiver is reset in the same domain and loses its contents too.
- Latency: beat accepted in cycle N appears on valid_o/data_o in cycle N+1.
- Credit visible: credit_i in cycle N raises credit_cnt_o and can re-enable ready_o in cycle N+1.
- Throughput: sustained 1 beat/cycle iff CREDITS >= receiver credit round-trip (send to credit return) in cycles; otherwise ready_o bubbles.
- ready_o deasserts in the cycle after the accept that consumed the last credit.

## Test plan
- Reset: hold rst=0 3 cycles, release -> credit_cnt_o=4, ready_o=1, valid_o=0, idle_o=1, err_o=0.
- Burst to empty: valid_i=1 data 0xA0..0xA5, no credits -> 0xA0..0xA3 appear on data_o cycles 1..4 with valid_o=1, cnt 3,2,1,0, ready_o=0 from cycle 4, 0xA4 held upstream.
- Return and resume: from cnt=0, pulse credit_i once -> next cycle cnt=1, ready_o=1; 0xA4 sent, cnt=0 again.
- Simultaneous: cnt=2, valid_i=1 and credit_i=1 every cycle for 10 cycles -> cnt stays 2, 10 beats out in order, ready_o never drops.
- Credit overflow: cnt=4, credit_i=1 with valid_i=0 -> cnt stays 4, err_o=1 and stays 1 through further traffic until reset.
- Async reset mid-burst: assert rst=0 between clock edges while valid_o=1, cnt=1 -> valid_o=0 and cnt=4 immediately, before next edge.
